// File: rtl/weights_loader.sv
// weights_loader: streams hidden-layer then output-layer weight bytes into two
// flat weight buses over a valid/ready byte interface.
// Optional checksum stage: define WEIGHTS_LOADER_CHECKSUM_EN to append a CHK
// state that receives a 16-bit sum (LSB first) and flags a mismatch on chk_err.
module weights_loader #(
    parameter int INPUT_COUNT   = 62,
    parameter int H_NODE_NUMBER = 20,
    parameter int O_NODE_NUMBER = 10
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     in_valid,
    input  logic [7:0]                               in_data,
    output logic                                     in_ready,
    output logic                                     busy,
    output logic                                     done,
    output logic [INPUT_COUNT*H_NODE_NUMBER*8-1:0]   h_data,
    output logic [H_NODE_NUMBER*O_NODE_NUMBER*8-1:0] o_data,
    output logic                                     chk_err
);

    localparam int H_TOTAL   = INPUT_COUNT * H_NODE_NUMBER;
    localparam int O_TOTAL   = H_NODE_NUMBER * O_NODE_NUMBER;
    localparam int MAX_TOTAL = (H_TOTAL > O_TOTAL) ? H_TOTAL : O_TOTAL;
    // Counter must reach the last index of the larger layer without wrapping.
    localparam int CNT_W     = (MAX_TOTAL > 1) ? $clog2(MAX_TOTAL) : 1;
    localparam int H_BITS    = H_TOTAL * 8;
    localparam int O_BITS    = O_TOTAL * 8;
    localparam int H_IDX_W   = (H_BITS > 1) ? $clog2(H_BITS) : 1;
    localparam int O_IDX_W   = (O_BITS > 1) ? $clog2(O_BITS) : 1;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] O_LAST = CNT_W'(O_TOTAL - 1);

`ifdef WEIGHTS_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_H = 3'd1,
        LOAD_O = 3'd2,
        CHK    = 3'd3,
        DONE   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_H = 3'd1,
        LOAD_O = 3'd2,
        DONE   = 3'd4
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [H_BITS-1:0]     h_data_q, h_data_d;
    logic [O_BITS-1:0]     o_data_q, o_data_d;
    logic [H_IDX_W-1:0]    h_idx;
    logic [O_IDX_W-1:0]    o_idx;
    logic                  accept;

`ifdef WEIGHTS_LOADER_CHECKSUM_EN
    logic [15:0]           sum_q, sum_d;
    logic [7:0]            lsb_q, lsb_d;
    logic                  chk_err_q, chk_err_d;
`endif

    assign accept = in_valid & in_ready;
    // Byte index scaled to a bit offset within each bus.
    assign h_idx  = H_IDX_W'({cnt_q, 3'b000});
    assign o_idx  = O_IDX_W'({cnt_q, 3'b000});

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only honoured when not loading.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) state_d = LOAD_H;
            end
            LOAD_H: begin
                if (accept && cnt_q == H_LAST) state_d = LOAD_O;
            end
            LOAD_O: begin
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
                if (accept && cnt_q == O_LAST) state_d = CHK;
`else
                if (accept && cnt_q == O_LAST) state_d = DONE;
`endif
            end
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept && cnt_q == CNT_W'(1)) state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            LOAD_H, LOAD_O: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
            CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: byte placement, counter and checksum tracking.
    always_comb begin
        cnt_d    = cnt_q;
        h_data_d = h_data_q;
        o_data_d = o_data_q;
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        lsb_d     = lsb_q;
        chk_err_d = chk_err_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cnt_d = '0;
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
                    sum_d     = '0;
                    chk_err_d = 1'b0;
`endif
                end
            end
            LOAD_H: begin
                if (accept) begin
                    h_data_d[h_idx +: 8] = in_data;
                    cnt_d = (cnt_q == H_LAST) ? '0 : cnt_q + CNT_W'(1);
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
                    sum_d = sum_q + {8'h00, in_data};
`endif
                end
            end
            LOAD_O: begin
                if (accept) begin
                    o_data_d[o_idx +: 8] = in_data;
                    cnt_d = (cnt_q == O_LAST) ? '0 : cnt_q + CNT_W'(1);
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
                    sum_d = sum_q + {8'h00, in_data};
`endif
                end
            end
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    if (cnt_q == '0) begin
                        lsb_d = in_data;
                        cnt_d = CNT_W'(1);
                    end else begin
                        chk_err_d = ({in_data, lsb_q} != sum_q);
                        cnt_d     = '0;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    // Datapath registers; reset clears the buses as well as control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            h_data_q <= '0;
            o_data_q <= '0;
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
            sum_q     <= '0;
            lsb_q     <= '0;
            chk_err_q <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            h_data_q <= h_data_d;
            o_data_q <= o_data_d;
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
            lsb_q     <= lsb_d;
            chk_err_q <= chk_err_d;
`endif
        end
    end

    assign h_data = h_data_q;
    assign o_data = o_data_q;
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: doc/weights_loader.md
WEIGHTS_LOADER -- requirements
Module: weights_loader

Interface
REQ-001 SHALL have parameter INPUT_COUNT, default 62, meaning inputs per hidden node.
REQ-002 SHALL have parameter H_NODE_NUMBER, default 20, meaning hidden-node count.
REQ-003 SHALL have parameter O_NODE_NUMBER, default 10, meaning output-node count.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-007 SHALL have port in_valid  input  1  in_data holds a valid weight byte.
REQ-008 SHALL have port in_data  input  8  weight byte, two's complement.
REQ-009 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port busy  output  1  load in progress.
REQ-011 SHALL have port done  output  1  load complete; holds until next start or rst.
REQ-012 SHALL have port h_data  output  INPUT_COUNT*H_NODE_NUMBER*8  flat hidden-layer weight bus.
REQ-013 SHALL have port o_data  output  H_NODE_NUMBER*O_NODE_NUMBER*8  flat output-layer weight bus.
REQ-014 SHALL have port chk_err  output  1  checksum mismatch flag.

Function
REQ-015 SHALL implement states IDLE, LOAD_H, LOAD_O, CHK, DONE.
REQ-016 SHALL transition IDLE or DONE -> LOAD_H on start, clearing byte counter, done and chk_err.
REQ-017 SHALL ignore start while in LOAD_H, LOAD_O or CHK.
REQ-018 SHALL accept a byte only on a cycle where in_valid and in_ready are both 1.
REQ-019 SHALL drive in_ready = 1 exactly in LOAD_H, LOAD_O and CHK, independent of in_valid.
REQ-020 SHALL drive busy = 1 exactly in LOAD_H, LOAD_O and CHK.
REQ-021 SHALL write the k-th accepted byte in LOAD_H to h_data[k*8 +: 8], k = 0..INPUT_COUNT*H_NODE_NUMBER-1.
REQ-022 SHALL write the k-th accepted byte in LOAD_O to o_data[k*8 +: 8], k = 0..H_NODE_NUMBER*O_NODE_NUMBER-1.
REQ-023 SHALL make an accepted byte visible on its bus the cycle after acceptance (1-cycle latency).
REQ-024 SHALL move LOAD_H -> LOAD_O on acceptance of hidden byte INPUT_COUNT*H_NODE_NUMBER-1 and reset the counter to 0.
REQ-025 SHALL leave LOAD_O on acceptance of output byte H_NODE_NUMBER*O_NODE_NUMBER-1, going to CHK or DONE (REQ-032).
REQ-026 SHALL size the byte counter to hold INPUT_COUNT*H_NODE_NUMBER-1; it never wraps within a state.
REQ-027 SHALL hold all bus contents unchanged outside accepted-byte cycles, including across a new start (old weights remain until overwritten).
REQ-028 SHALL not alter state or buses on cycles with in_valid = 0 (stalls of any length tolerated).

Reset
REQ-029 SHALL on rst asynchronously force state IDLE, counter 0, in_ready 0, busy 0, done 0, chk_err 0, h_data all 0, o_data all 0.
REQ-030 SHALL on rst asserted mid-load abandon the load; the next load starts from byte 0 after a new start.
REQ-031 SHALL ignore start, in_valid and in_data while rst is 1.

Configuration
REQ-032 SHALL support macro WEIGHTS_LOADER_CHECKSUM_EN.
REQ-033 SHALL, with WEIGHTS_LOADER_CHECKSUM_EN defined: accumulate a 16-bit wrap-around unsigned sum of all weight bytes; LOAD_O -> CHK; in CHK accept 2 bytes (sum LSB then MSB); on the second, set chk_err = 1 if received != accumulated, then go to DONE.
REQ-034 SHALL, without WEIGHTS_LOADER_CHECKSUM_EN: no CHK state, no accumulator, LOAD_O -> DONE directly, chk_err tied to 0.
REQ-035 SHALL assert done = 1 the cycle after the final accepted byte in both configurations.

Verification
REQ-036 SHALL cover: rst, start, stream 1440 bytes value (k mod 256) with in_valid constant 1 -> h_data[0+:8]=0x00, h_data[1239*8+:8]=0xD7, o_data[0+:8]=0xD8, o_data[199*8+:8]=0x9F, done=1 1 cycle after last byte (macro off).
REQ-037 SHALL cover: same stream with in_valid toggling every other cycle -> identical final buses, busy high for 2879 cycles.
REQ-038 SHALL cover: rst pulsed after 500 hidden bytes -> all outputs 0 immediately; new start plus 1440 bytes 0x11 -> all bytes 0x11, done=1.
REQ-039 SHALL cover: start pulsed at byte 700 -> ignored, counter continues, done after byte 1439 only.
REQ-040 SHALL cover (macro on): 1440 bytes 0x01 then checksum 0xA0,0x05 -> chk_err=0, done=1; repeat with 0xA1,0x05 -> chk_err=1, done=1.
